// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: bus word addresses, CTRL field
// positions, mode codes and the FSM state type.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } timer_state_e;

endpackage

// File: rtl/timer_dev_if.sv
// Device-bus view of the timer: address/strobe/write data in, read data and
// interrupt request out.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_dev.sv
// Programmable down-counter with one-shot or auto-reload interrupt generation,
// memory-mapped as CTRL / PRESET / COUNT on the device bus.
module timer_dev
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  timer_dev_if.slave   bus
);

  timer_state_e      state_q,  state_d;
  logic [3:0]        ctrl_q,   ctrl_d;
  logic [CNT_W-1:0]  preset_q, preset_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              sticky_q, sticky_d;

  logic       en;
  logic [1:0] mode;
  assign en   = ctrl_q[CTRL_EN];
  assign mode = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    unique case (state_q)
      IDLE: if (en) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // Reaching 1 or starting at 0 both terminate here; COUNT floors at 0.
          count_d = '0;
          state_d = INT;
        end
      end
      INT: begin
        if (mode == MODE_RELOAD) begin
          state_d = LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          sticky_d        = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes override the FSM's own CTRL/sticky update in the same cycle.
    if (bus.we) begin
      if (bus.addr == ADDR_CTRL) begin
        ctrl_d   = bus.din[3:0];
        sticky_d = 1'b0;
        if (!bus.din[CTRL_EN]) state_d = IDLE;
      end else if (bus.addr == ADDR_PRESET) begin
        preset_d = bus.din[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    unique case (bus.addr)
      ADDR_CTRL:   bus.dout = 32'(ctrl_q);
      ADDR_PRESET: bus.dout = 32'(preset_q);
      ADDR_COUNT:  bus.dout = 32'(count_q);
      default:     bus.dout = '0;
    endcase
  end

  assign bus.irq = ctrl_q[CTRL_IM] & ((state_q == INT) | sticky_q);

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Programmable down-counter peripheral on the processor's external device bus.
- Sits downstream of the multi-cycle datapath. It consumes the datapath's device address and write data (PrAddr, PrWD), qualified by the system bridge.
- Returns read data on PrRD and drives IntReq back into the CP0/interrupt path.
- Provides a periodic or one-shot interrupt source for exception-handler testing.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers; zero-extended to 32 bits on read.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately, released synchronously to clk.
- addr  input  2  word select, PrAddr[3:2]: 00 CTRL, 01 PRESET, 10 COUNT, 11 reserved.
- we  input  1  write strobe, already qualified by the bridge's device select.
- din  input  32  write data (PrWD).
- dout  output  32  combinational read data (to PrRD).
- irq  output  1  interrupt request (to IntReq).

Behaviour:
- CTRL bits:
  - [0] EN: count enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00.
  - [3] IM: interrupt mask, 1 = enabled.
  - [31:4] read as 0.
- Reset (rst=0, asynchronous):
  - CTRL=0, PRESET=0, COUNT=0, sticky=0, state=IDLE.
  - Therefore irq=0 and dout=0 for every addr.
- Read path: dout = CTRL, PRESET or COUNT per addr, zero-extended. Reserved address reads 0. Reads have no side effects.
- Write path, effective at the clock edge with we=1:
  - CTRL <= din[3:0]; also clears sticky.
  - PRESET <= din[CNT_W-1:0]; COUNT is not changed until the next LOAD.
  - Writes to COUNT or the reserved address are ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: COUNT holds. EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT holds.
    - COUNT>1 -> COUNT-1, stay in CNT.
    - COUNT==1 -> COUNT <= 0, go to INT.
    - COUNT==0 (PRESET was 0) -> INT, COUNT stays 0.
  - INT, MODE 01: next state LOAD (reload period).
  - INT, MODE other: EN <= 0, sticky <= 1, next state IDLE.
- irq = IM & ((state==INT) | sticky).
  - Auto-reload: one-cycle pulse per period.
  - One-shot: level, held until a CTRL write.
- Latency and period:
  - A CTRL write with EN=1 at edge t gives LOAD at t+1, COUNT=PRESET=N at t+2, and INT (irq high) at t+2+N for N>=1.
  - With N=0, INT occurs at t+3.
  - Auto-reload period is N+2 cycles (INT, LOAD, N CNT cycles).
- Simultaneous events: a bus write to CTRL takes priority over the FSM's own CTRL update in INT. Writing EN=0 in any state forces the next state to IDLE.
- Sticky in INT together with a CTRL write: the write wins and sticky is 0.
- COUNT never wraps below 0.
- Changing IM does not alter counting or sticky; it only gates irq.
- Asserting reset mid-count returns to IDLE with all registers cleared.

Decomposition:
- Shared package timer_pkg holds:
  - Address constants: ADDR_CTRL=2'b00, ADDR_PRESET=2'b01, ADDR_COUNT=2'b10.
  - CTRL bit indices: EN=0, MODE=2:1, IM=3.
  - Mode codes: MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01.
  - State encoding: IDLE, LOAD, CNT, INT.
- No sub-module: register file, read mux and FSM fit in one module.

Test Plan:
- Reset check: assert rst=0 mid-count with COUNT=7 -> COUNT, CTRL, PRESET and dout read 0 and irq=0 immediately; after release the FSM stays in IDLE.
- One-shot: write PRESET=5, then CTRL=0x9 (EN, IM, mode 00) at edge t -> COUNT reads 5 at t+2 and 0 at t+7; irq rises at t+7 and stays high; CTRL reads 0x8. A CTRL=0x0 write drops irq next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> irq is a one-cycle pulse every 5 cycles, repeated 4 times; COUNT sequence 3,2,1,0,(0),3,...
- Mask: PRESET=2, CTRL=0x1 (IM=0) -> no irq, CTRL EN bit clears. A later CTRL write with IM=1 also clears sticky, so irq stays 0.
- Pause and edge cases:
  - PRESET=10, enable, clear EN after 4 CNT cycles -> COUNT holds at 6.
  - Re-enable -> reload to 10.
  - PRESET=0 -> irq at t+3.
- Bus corner cases: write to COUNT or reserved address changes nothing; reserved reads 0; a PRESET write during CNT changes only the next reload value.
